// File: rtl/uart_pkg.sv
// uart_pkg: register map, STATUS bit positions and receiver FSM encoding
// shared by the uart_rx slice.
package uart_pkg;

  // Register select, decoded from addr[2]
  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  // STATUS register bit positions
  localparam int ST_NE   = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVR  = 2;
  localparam int ST_FERR = 3;
  localparam int ST_PERR = 4;

  // Receiver frame states
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous byte FIFO for the receiver. Pointers carry one
// extra wrap bit so full/empty fall out of a plain compare. A pop on a full
// FIFO frees the head slot in the same cycle, so a simultaneous push is kept.
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [7:0]                    wdata,
  output logic [7:0]                    head,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && !do_push;
  assign head     = mem[rd_ptr[AW-1:0]];

  // Advance read/write pointers on accepted pops and pushes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: contents are only visible behind a valid pointer
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a receive FIFO and DATA/STATUS registers
// on the CPU peripheral bus. Defining UART_RX_PARITY_EN switches the frame
// to 8E1 and enables the PERR sticky bit in STATUS.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 20_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic        wr,
  input  logic        valid,
  output logic [31:0] dout,
  output logic        irq,
  input  logic        rxd
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_RELOAD  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(DIV / 2 - 1);

  logic            rxd_meta;
  logic            rxd_s;
  rx_state_t       state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            push_req;
  logic            ferr_pulse;
  logic            valid_q;
  logic            pop_pending;
  logic            data_rd;
  logic            status_w1c;
  logic            fifo_pop;
  logic            ovr;
  logic            ferr;
  logic [7:0]      head;
  logic [AW:0]     count;
  logic            full;
  logic            empty;
  logic            fifo_ovf;
  logic [31:0]     status;
  logic            unused_bus;
`ifdef UART_RX_PARITY_EN
  logic            perr_pulse;
  logic            par_bad;
  logic            perr;
`endif

  // Bring the asynchronous line into the clock domain; idle level is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  // Frame FSM: half a bit to the start-bit centre, then one bit period per sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      push_req   <= 1'b0;
      ferr_pulse <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_pulse <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      push_req   <= 1'b0;
      ferr_pulse <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_pulse <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state <= START;
            cnt   <= HALF_RELOAD;
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rxd_s) begin
            state <= IDLE;
          end else begin
            state   <= DATA;
            cnt     <= BIT_RELOAD;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg   <= {rxd_s, shreg[7:1]};
            cnt     <= BIT_RELOAD;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            par_bad    <= rxd_s ^ (^shreg);
            perr_pulse <= rxd_s ^ (^shreg);
            cnt        <= BIT_RELOAD;
            state      <= STOP;
          end
        end
`endif
        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rxd_s) begin
`ifdef UART_RX_PARITY_EN
            push_req <= !par_bad;
`else
            push_req <= 1'b1;
`endif
            state <= IDLE;
          end else begin
            ferr_pulse <= 1'b1;
            state      <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          if (rxd_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_req),
    .pop      (fifo_pop),
    .wdata    (shreg),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (fifo_ovf)
  );

  assign data_rd    = valid && !wr && (addr[2] == REG_DATA);
  assign status_w1c = valid && !valid_q && wr && (addr[2] == REG_STATUS);
  assign fifo_pop   = pop_pending && !valid;
  assign irq        = !empty;

  // A DATA read pops once, in the first cycle after the strobe drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      pop_pending <= 1'b0;
    end else begin
      valid_q <= valid;
      if (data_rd) begin
        pop_pending <= 1'b1;
      end else if (!valid) begin
        pop_pending <= 1'b0;
      end
    end
  end

  // Sticky error bits: a new error in the same cycle as a clear keeps the bit set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr <= 1'b0;
`endif
    end else begin
      ovr  <= fifo_ovf   | (ovr  & ~(status_w1c & din[ST_OVR]));
      ferr <= ferr_pulse | (ferr & ~(status_w1c & din[ST_FERR]));
`ifdef UART_RX_PARITY_EN
      perr <= perr_pulse | (perr & ~(status_w1c & din[ST_PERR]));
`endif
    end
  end

  // Read mux straight from current register state
  always_comb begin
    status          = '0;
    status[ST_NE]   = !empty;
    status[ST_FULL] = full;
    status[ST_OVR]  = ovr;
    status[ST_FERR] = ferr;
`ifdef UART_RX_PARITY_EN
    status[ST_PERR] = perr;
`else
    status[ST_PERR] = 1'b0;
`endif
    status[15:8]    = 8'(count);
    if (addr[2] == REG_DATA) begin
      dout = {23'b0, !empty, head};
    end else begin
      dout = status;
    end
  end

  // Bus bits outside the decoded register fields
`ifdef UART_RX_PARITY_EN
  assign unused_bus = ^{addr[31:3], addr[1:0], din[31:5], din[1:0]};
`else
  assign unused_bus = ^{addr[31:3], addr[1:0], din[31:5], din[ST_PERR], din[1:0]};
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver on the board `rxd` pin; converts 8N1 frames into bytes.
- Buffers received bytes in a small FIFO.
- Exposes DATA and STATUS registers on the CPU peripheral bus at 0x16xx_xxxx, next to the transmit-only UART.
- The system controller supplies `ready`; this block only decodes `valid`/`wr`/`addr` and drives `dout`.

Parameters:
- CLK_HZ, 20_000_000, system clock frequency.
- BAUD, 115200, line rate; bit period DIV = CLK_HZ/BAUD (integer, truncated; 173 at defaults).
- FIFO_DEPTH, 16, receive FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- addr  in  32  CPU byte address; only addr[2] is decoded (0 = DATA, 1 = STATUS).
- din  in  32  CPU write data.
- wr  in  1  1 = write, 0 = read.
- valid  in  1  access strobe, already qualified by the area decode; may stay high for several cycles.
- dout  out  32  read data; combinational from the current register state.
- irq  out  1  high while the FIFO is not empty.
- rxd  in  1  asynchronous serial input; idles high.

Behaviour:
- Reset: FSM=IDLE, FIFO empty, sticky error bits 0, synchronizer flops 1, irq=0, dout reflects the empty state.
- Input path: 2-flop synchronizer feeds rxd_s. Adds 2 cycles of latency; jitter tolerance is ±1 cycle per bit.
- Bit counter: counts DIV cycles per bit; reloads at each state entry.
- FSM transitions:
  - IDLE: rxd_s==0 -> START with counter = DIV/2.
  - START: at terminal count, rxd_s==1 -> IDLE (glitch, nothing recorded); else -> DATA with bit index 0.
  - DATA: sample rxd_s at mid-bit, LSB first, 8 bits, then -> STOP.
  - STOP: at mid-bit, rxd_s==1 -> push byte, -> IDLE. rxd_s==0 -> set FERR, discard byte, -> WAIT_HIGH.
  - WAIT_HIGH: stay until rxd_s==1 (break or line held low), then -> IDLE.
- Push occurs 1 cycle after the stop-bit sample. Frame-end to irq rise is ≤2 cycles.
- DATA read: dout = {23'b0, ~empty, head_byte}. When empty, dout[8]=0 and dout[7:0]=last head contents, which are don't-care.
- Pop timing: a read of DATA sets pop_pending while valid is high. The pop happens in the first cycle valid is low, so multi-cycle strobes pop exactly once.
- Pop when empty: no-op.
- STATUS read bit map:
  - [0] not empty
  - [1] full
  - [2] OVR (sticky)
  - [3] FERR (sticky)
  - [4] PERR (sticky)
  - [15:8] count, zero-extended
  - all other bits 0
- STATUS write: W1C on bits [4:2]; applied once per access, on the first cycle of valid.
- Writes to DATA are ignored.
- Push to a full FIFO: byte dropped, OVR set. Exception: a pop in the same cycle frees a slot first, the push succeeds and OVR is not set.
- Push and pop in the same cycle on an empty FIFO: no pop, push succeeds, count=1.
- Sticky error set and W1C clear in the same cycle: set wins.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits; full and empty come from MSB comparison; wrap-around is natural binary.
- Asserting rst_n low mid-frame aborts the frame; no partial byte is ever stored.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1; a PARITY state sits between DATA and STOP.
  - Received parity bit XOR the 8 data bits must be 0.
  - On mismatch, set PERR and discard the byte; the stop bit is still checked.
- Undefined:
  - 8N1 frame, no PARITY state.
  - STATUS[4] reads 0 and ignores writes.

Decomposition:
- Package uart_pkg holds:
  - register offsets DATA=0, STATUS=1 (addr[2]);
  - STATUS bit indices ST_NE, ST_FULL, ST_OVR, ST_FERR, ST_PERR;
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH).
- Sub-module uart_rx_fifo: synchronous FIFO with push/pop, head, count, full and empty. Same clk/rst_n, parameterised by FIFO_DEPTH.

Test Plan:
- Frame 0xA5 at DIV=173 -> within 2 cycles of the stop sample, irq=1 and DATA read = 0x000001A5. After valid drops, count=0 and irq=0.
- 17 frames 0x00..0x10, no reads -> STATUS = 0x1007 (count 16, full, not empty, OVR). DATA reads return 0x00..0x0F in order; 0x10 is lost.
- 40-cycle low glitch on rxd -> no push, FSM back in IDLE, STATUS=0.
- Frame with stop bit low (0x55, then rxd held low for 3 bit-times) -> FERR=1, count=0. No new frame starts until rxd is high. Writing STATUS 0x8 clears FERR.
- Full FIFO, frame completes in the same cycle a pop fires -> count stays 16, OVR=0, new byte is the last entry.
- With UART_RX_PARITY_EN: frame 0x03 with parity bit 1 -> PERR=1, byte discarded. Same frame with parity 0 -> stored, DATA=0x103.
